// File: rtl/rvc_pkg.sv
// Shared RV32/RVC definitions for the compress-and-pack datapath.
// Holds the opcode constants, the C.NOP halfword and the pack-state enum.
package rvc_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [15:0] C_NOP = 16'h0001;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_e;

    // x8..x15 are the only registers reachable from the 3-bit RVC fields.
    function automatic logic is_creg(input logic [4:0] r);
        return r[4:3] == 2'b01;
    endfunction

endpackage

// File: rtl/rvc_compress_packer_if.sv
// Instruction-in / packed-word-out stream bundle for the packer.
// Handshake: a beat transfers on a rising edge where valid && ready; the
// producer holds valid and payload stable until that edge, and ready may
// depend combinationally on valid.
interface rvc_compress_packer_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;

    modport master (
        output in_valid, in_inst, flush, out_ready,
        input  in_ready, out_valid, out_word
    );

    modport slave (
        input  in_valid, in_inst, flush, out_ready,
        output in_ready, out_valid, out_word
    );

endinterface

// File: rtl/rvc_compress_encode.sv
// Purely combinational RV32I -> RVC encoder for the subset the packer uses.
// Anything outside that subset reports compressible = 0.
module rvc_compress_encode
    import rvc_pkg::*;
(
    input  logic [31:0] inst,
    output logic [15:0] c16,
    output logic        compressible
);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm_i;
    logic [11:0] imm_s;
    logic        imm_i_small;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];
    assign imm_i  = inst[31:20];
    assign imm_s  = {inst[31:25], inst[11:7]};

    // Fits the 6-bit signed immediate of C.LI / C.ADDI.
    assign imm_i_small = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f);

    always_comb begin
        c16          = 16'h0000;
        compressible = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                if (funct3 == 3'b000) begin
                    if (rd == 5'd0 && rs1 == 5'd0 && imm_i == 12'd0) begin
                        c16          = C_NOP;
                        compressible = 1'b1;
                    end else if (rd != 5'd0 && rs1 == 5'd0 && imm_i_small) begin
                        c16          = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
                        compressible = 1'b1;
                    end else if (rd != 5'd0 && rs1 == rd && imm_i != 12'd0 && imm_i_small) begin
                        c16          = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
                        compressible = 1'b1;
                    end
                end else if (funct3 == 3'b001 && funct7 == 7'd0 && rd != 5'd0 &&
                             rs1 == rd && rs2 != 5'd0) begin
                    c16          = {3'b000, 1'b0, rd, rs2, 2'b10};
                    compressible = 1'b1;
                end
            end
            OPC_OP: begin
                if (funct3 == 3'b000 && funct7 == 7'd0 && rd != 5'd0 && rs2 != 5'd0) begin
                    if (rs1 == 5'd0) begin
                        c16          = {4'b1000, rd, rs2, 2'b10};
                        compressible = 1'b1;
                    end else if (rs1 == rd) begin
                        c16          = {4'b1001, rd, rs2, 2'b10};
                        compressible = 1'b1;
                    end
                end
            end
            OPC_LOAD: begin
                if (funct3 == 3'b010 && is_creg(rd) && is_creg(rs1) &&
                    imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'b00) begin
                    c16 = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
                    compressible = 1'b1;
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b010 && is_creg(rs2) && is_creg(rs1) &&
                    imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'b00) begin
                    c16 = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
                    compressible = 1'b1;
                end
            end
            OPC_JALR: begin
                if (funct3 == 3'b000 && imm_i == 12'd0 && rs1 != 5'd0 && rd[4:1] == 4'd0) begin
                    c16          = {3'b100, rd[0], rs1, 5'd0, 2'b10};
                    compressible = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/rvc_compress_packer.sv
// Compresses an RV32I stream where possible and packs the result into
// 32-bit memory words; a lone halfword waits in the hold register.
module rvc_compress_packer
    import rvc_pkg::*;
#(
    parameter int COUNT_W         = 16,
    parameter int ENABLE_COMPRESS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_inst,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_word,
    output logic [COUNT_W-1:0] comp_count,
    output pack_state_e        dbg_state
);

    pack_state_e        state_q, state_d;
    logic [15:0]        hold_q, hold_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_word_q, out_word_d;
    logic [COUNT_W-1:0] comp_count_q, comp_count_d;

    logic [15:0] enc_c16;
    logic        enc_ok;
    logic        is_comp;
    logic        slot_free;
    logic        accept;

    rvc_compress_encode u_encode (
        .inst         (in_inst),
        .c16          (enc_c16),
        .compressible (enc_ok)
    );

    assign is_comp   = (ENABLE_COMPRESS != 0) && enc_ok;
    assign slot_free = !out_valid_q || out_ready;
    // An incompressible input arriving in HALF is stalled one cycle while the
    // pending halfword is padded out on its own.
    assign in_ready  = rst_n && slot_free && !flush &&
                       !(state_q == HALF && in_valid && !is_comp);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_word_d   = out_word_q;
        comp_count_d = comp_count_q;
        if (slot_free) begin
            if (flush) begin
                if (state_q == HALF) begin
                    out_word_d  = {C_NOP, hold_q};
                    out_valid_d = 1'b1;
                    state_d     = EMPTY;
                    hold_d      = 16'h0000;
                end
            end else if (accept) begin
                if (is_comp) begin
                    if (comp_count_q != '1) begin
                        comp_count_d = comp_count_q + COUNT_W'(1);
                    end
                    if (state_q == EMPTY) begin
                        hold_d  = enc_c16;
                        state_d = HALF;
                    end else begin
                        out_word_d  = {enc_c16, hold_q};
                        out_valid_d = 1'b1;
                        state_d     = EMPTY;
                        hold_d      = 16'h0000;
                    end
                end else begin
                    out_word_d  = in_inst;
                    out_valid_d = 1'b1;
                end
            end else if (state_q == HALF && in_valid) begin
                out_word_d  = {C_NOP, hold_q};
                out_valid_d = 1'b1;
                state_d     = EMPTY;
                hold_d      = 16'h0000;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            hold_q       <= 16'h0000;
            out_valid_q  <= 1'b0;
            out_word_q   <= 32'h0000_0000;
            comp_count_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            comp_count_q <= comp_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_word   = out_word_q;
    assign comp_count = comp_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_rvc_compress_packer.sv
// Scenario bench for rvc_compress_packer: expected words are queued as
// stimulus is driven and compared against the words the DUT hands off.
module tb_rvc_compress_packer;
    import rvc_pkg::*;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] comp_count;
    pack_state_e   dbg_state;

    rvc_compress_packer_if bus ();

    rvc_compress_packer #(
        .COUNT_W         (CW),
        .ENABLE_COMPRESS (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (bus.in_valid),
        .in_ready   (bus.in_ready),
        .in_inst    (bus.in_inst),
        .flush      (bus.flush),
        .out_valid  (bus.out_valid),
        .out_ready  (bus.out_ready),
        .out_word   (bus.out_word),
        .comp_count (comp_count),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          tests;
    int          fails;
    logic        rand_bp;

    // Handshake completes on the next rising edge; out_ready only moves just after an edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_word);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] inst, output int stalls);
        int n;
        stalls       = 0;
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            stalls++;
            tick();
        end
        if (n == 100) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: inst=%h never accepted, in_ready=%b required 1", inst, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        logic [31:0] e;
        logic [31:0] g;
        for (int n = 0; n < 200 && got_q.size() < exp_q.size(); n++) tick();
        repeat (4) tick();
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL %s_word: got %h required %h", name, g, e);
            end
        end
        tests++;
        if (got_q.size() != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_count: %0d extra words, %0d missing words, required 0/0",
                     name, got_q.size(), exp_q.size());
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = 32'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b required 0", bus.in_ready); end
        tests++;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        tests++;
        if (bus.out_word !== 32'h0) begin fails++; $display("FAIL reset_out_word: got %h required 0", bus.out_word); end
        tests++;
        if (comp_count !== '0) begin fails++; $display("FAIL reset_comp_count: got %0d required 0", comp_count); end
        tests++;
        if (dbg_state !== EMPTY) begin fails++; $display("FAIL reset_state: got %0d required EMPTY", dbg_state); end
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b required 1", bus.in_ready); end
        tick();
    endtask

    task automatic test_pairing();
        int s;
        exp_q.push_back(32'h95B2_0515);
        send(32'h0055_0513, s);
        @(negedge clk);
        tests++;
        if (dbg_state !== HALF) begin fails++; $display("FAIL pair_half_state: got %0d required HALF", dbg_state); end
        tick();
        send(32'h00C5_85B3, s);
        wait_drain("pairing");
        tests++;
        if (comp_count !== CW'(2)) begin fails++; $display("FAIL pair_count: got %0d required 2", comp_count); end
    endtask

    task automatic test_padding();
        int s;
        exp_q.push_back(32'h0001_0515);
        exp_q.push_back(32'h1234_52B7);
        send(32'h0055_0513, s);
        send(32'h1234_52B7, s);
        tests++;
        if (s != 1) begin fails++; $display("FAIL pad_stall: in_ready low %0d cycles required 1", s); end
        wait_drain("padding");
        tests++;
        if (comp_count !== CW'(3)) begin fails++; $display("FAIL pad_count: got %0d required 3", comp_count); end
    endtask

    task automatic test_flush();
        int s;
        exp_q.push_back(32'h0001_40C0);
        send(32'h0044_A403, s);
        pulse_flush();
        wait_drain("flush_half");
        pulse_flush();
        wait_drain("flush_empty");
        @(negedge clk);
        tests++;
        if (dbg_state !== EMPTY) begin fails++; $display("FAIL flush_state: got %0d required EMPTY", dbg_state); end
        tick();
    endtask

    task automatic test_backpressure();
        int s;
        exp_q.push_back(32'h1234_52B7);
        exp_q.push_back(32'h0010_0013);
        bus.out_ready = 1'b0;
        send(32'h1234_52B7, s);
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h0010_0013;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h1234_52B7 || bus.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold cycle %0d: valid=%b word=%h in_ready=%b required 1/123452b7/0",
                         i, bus.out_valid, bus.out_word, bus.in_ready);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        send(32'h0010_0013, s);
        wait_drain("backpressure");
    endtask

    task automatic test_boundary();
        logic [31:0] insts [5];
        int s;
        insts = '{32'h0205_0513, 32'h0080_00EF, 32'h0044_A283, 32'h0000_0000, 32'h0010_0013};
        foreach (insts[i]) begin
            exp_q.push_back(insts[i]);
            send(insts[i], s);
        end
        wait_drain("boundary");
        tests++;
        if (comp_count !== CW'(4)) begin fails++; $display("FAIL boundary_count: got %0d required 4", comp_count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] insts [9];
        logic [15:0] c16s  [9];
        int s;
        insts = '{32'h0000_0013, 32'hFFF0_0293, 32'h0033_1313, 32'h0090_03B3, 32'h00A5_A423,
                  32'h0002_80E7, 32'h0000_8067, 32'h07C4_2783, 32'hFE05_0513};
        c16s  = '{16'h0001, 16'h52FD, 16'h030E, 16'h83A6, 16'hC588,
                  16'h9282, 16'h8082, 16'h5C7C, 16'h1501};
        for (int i = 0; i < 8; i += 2) exp_q.push_back({c16s[i+1], c16s[i]});
        exp_q.push_back({16'h0001, c16s[8]});
        foreach (insts[i]) send(insts[i], s);
        pulse_flush();
        wait_drain("back_to_back");
        tests++;
        if (comp_count !== CW'(13)) begin fails++; $display("FAIL b2b_count: got %0d required 13", comp_count); end
    endtask

    task automatic test_reset_half();
        int s;
        send(32'h0055_0513, s);
        @(negedge clk);
        tests++;
        if (dbg_state !== HALF) begin fails++; $display("FAIL rst_half_state: got %0d required HALF", dbg_state); end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_half_in_ready: got %b required 0", bus.in_ready); end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        wait_drain("reset_half_quiet");
        tests++;
        if (comp_count !== '0) begin fails++; $display("FAIL rst_half_count: got %0d required 0", comp_count); end
        exp_q.push_back(32'h95B2_0515);
        send(32'h0055_0513, s);
        send(32'h00C5_85B3, s);
        wait_drain("reset_half_pair");
        tests++;
        if (comp_count !== CW'(2)) begin fails++; $display("FAIL rst_half_pair_count: got %0d required 2", comp_count); end
    endtask

    task automatic test_saturation();
        logic [4:0]  imm;
        logic [15:0] lo;
        logic [15:0] c;
        int s;
        rand_bp = 1'b1;
        for (int i = 0; i < 20; i++) begin
            imm = 5'($urandom_range(1, 31));
            c   = {3'b000, 1'b0, 5'd10, imm, 2'b01};
            if (i % 2 == 0) lo = c;
            else exp_q.push_back({c, lo});
            send({7'd0, imm, 5'd10, 3'b000, 5'd10, 7'h13}, s);
        end
        rand_bp       = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain("saturation");
        tests++;
        if (comp_count !== '1) begin fails++; $display("FAIL sat_count: got %0d required %0d", comp_count, (1 << CW) - 1); end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rand_bp = 1'b0;
        test_reset();
        test_pairing();
        test_padding();
        test_flush();
        test_backpressure();
        test_boundary();
        test_back_to_back();
        test_reset_half();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
